// File: rtl/dot_product_seq.sv
// dot_product_seq: serial Q(WIDTH-QP).QP dot product, one shared multiplier, LEN cycles per result
// Optional macro DOTP_SEQ_SATURATE_EN: widened accumulator with clamped result
module dot_product_seq #(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN*WIDTH-1:0] vec1_packed,
  input  logic [LEN*WIDTH-1:0] vec2_packed,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     dotp_out
);
  localparam int IW = $clog2(LEN);
  localparam int PW = 2 * WIDTH;
`ifdef DOTP_SEQ_SATURATE_EN
  localparam int AW = WIDTH + IW;
`else
  localparam int AW = WIDTH;
`endif
  typedef enum logic {IDLE, MAC} state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_idx;
  logic [AW-1:0]         r_acc, w_sum;
  logic [LEN*WIDTH-1:0]  r_v1, r_v2;
  logic signed [PW-1:0]  w_a, w_b;
  logic [WIDTH-1:0]      w_term, w_res, r_dotp;
  logic                  w_last, r_done;
  assign w_a    = PW'($signed(r_v1[r_idx*WIDTH +: WIDTH]));
  assign w_b    = PW'($signed(r_v2[r_idx*WIDTH +: WIDTH]));
  assign w_term = WIDTH'((w_a * w_b) >>> QP);
  assign w_last = r_idx == IW'(LEN - 1);
`ifdef DOTP_SEQ_SATURATE_EN
  assign w_sum = r_acc + {{(AW-WIDTH){w_term[WIDTH-1]}}, w_term};
  // in range iff all bits above the result sign agree with it
  assign w_res = (&w_sum[AW-1:WIDTH-1] || ~|w_sum[AW-1:WIDTH-1]) ? w_sum[WIDTH-1:0]
               : {w_sum[AW-1], {(WIDTH-1){~w_sum[AW-1]}}};
`else
  assign w_sum = r_acc + w_term;
  assign w_res = w_sum;
`endif
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? MAC : IDLE) : (w_last ? IDLE : MAC);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_dotp  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == IDLE && start) begin
        r_v1  <= vec1_packed;
        r_v2  <= vec2_packed;
        r_idx <= '0;
        r_acc <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_last ? '0 : w_sum;
        r_idx <= w_last ? '0 : r_idx + IW'(1);
        if (w_last) begin
          r_dotp <= w_res;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign busy     = r_state == MAC;
  assign done     = r_done;
  assign dotp_out = r_dotp;
endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: directed + scoreboarded checks of dot_product_seq (honours DOTP_SEQ_SATURATE_EN)
module tb_dot_product_seq;
  localparam int W = 16, QP = 12, L = 8;
  logic clk = 1'b0, rst, start;
  logic [L*W-1:0] v1, v2;
  logic busy, done;
  logic [W-1:0] dotp;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  dot_product_seq #(.WIDTH(W), .QP(QP), .LEN(L)) dut (
    .clk(clk), .rst(rst), .start(start), .vec1_packed(v1), .vec2_packed(v2),
    .busy(busy), .done(done), .dotp_out(dotp));

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [L*W-1:0] rv();
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    int s, p, t;
    logic signed [W-1:0] t16;
    s = 0;
    for (int i = 0; i < L; i++) begin
      p = int'($signed(a[i*W +: W])) * int'($signed(b[i*W +: W]));
      t = p >>> QP;
      t16 = t[W-1:0];
      s += int'(t16);
    end
`ifdef DOTP_SEQ_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[W-1:0];
  endfunction

  task automatic wait_done(input bit disturb, output int n, output int bc);
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 4*L) begin
      if (busy) bc++;
      if (disturb) begin
        start = (n >= 2 && n <= 5);
        v1 = rv();
        v2 = rv();
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic result(input string tag);
    check({tag, " done"}, W'(done), 16'd1);
    check({tag, " busy@done"}, W'(busy), 16'd0);
    check({tag, " sb"}, W'(q.size() > 0), 16'd1);
    if (q.size() > 0) check(tag, dotp, q.pop_front());
  endtask

  task automatic op(input string tag, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                    input logic [W-1:0] exp, input bit disturb);
    int n, bc;
    v1 = a;
    v2 = b;
    start = 1'b1;
    q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    wait_done(disturb, n, bc);
    check({tag, " latency"}, W'(n), W'(L));
    check({tag, " busy cycles"}, W'(bc), W'(L));
    result(tag);
    @(negedge clk);
    check({tag, " done pulse"}, W'(done), 16'd0);
    check({tag, " idle"}, W'(busy), 16'd0);
  endtask

  initial begin
    logic [L*W-1:0] a, b;
    int n, bc;
    rst = 1'b1;
    start = 1'b0;
    v1 = '0;
    v2 = '0;
    repeat (2) @(negedge clk);
    check("rst busy", W'(busy), 16'd0);
    check("rst done", W'(done), 16'd0);
    check("rst dotp", dotp, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    op("half*half", {L{16'h0800}}, {L{16'h0800}}, 16'h2000, 1'b0);
    op("neg half", {L{16'hF800}}, {L{16'h0800}}, 16'hE000, 1'b0);
    a = '0;
    b = '0;
    a[W-1:0] = 16'hFFFF;
    b[W-1:0] = 16'h0001;
    op("floor", a, b, 16'hFFFF, 1'b0);
`ifdef DOTP_SEQ_SATURATE_EN
    op("overflow", {L{16'h1000}}, {L{16'h1000}}, 16'h7FFF, 1'b0);
`else
    op("overflow", {L{16'h1000}}, {L{16'h1000}}, 16'h8000, 1'b0);
`endif
    op("neg overflow", {L{16'hF000}}, {L{16'h1800}}, model({L{16'hF000}}, {L{16'h1800}}), 1'b0);
    a = rv();
    b = rv();
    op("random", a, b, model(a, b), 1'b0);
    a = rv();
    b = rv();
    op("start busy", a, b, model(a, b), 1'b1);
    // abort partway through MAC, reset asserted between clock edges
    v1 = {L{16'h0800}};
    v2 = {L{16'h0800}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", W'(busy), 16'd0);
    check("async rst done", W'(done), 16'd0);
    check("async rst dotp", dotp, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a = rv();
    b = rv();
    op("after rst", a, b, model(a, b), 1'b0);
    // start held high: a new operand pair is presented in each done cycle
    v1 = rv();
    v2 = rv();
    q.push_back(model(v1, v2));
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0, n, bc);
      check("b2b period", W'(k == 0 ? n : n + 1), W'(k == 0 ? L : L + 1));
      result("b2b");
      if (k < 3) begin
        v1 = rv();
        v2 = rv();
        q.push_back(model(v1, v2));
      end else start = 1'b0;
      @(negedge clk);
    end
    check("b2b stop", W'(busy), 16'd0);
    check("sb empty", W'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Serial, resource-shared replacement for the combinational dot-product path: one WIDTH×WIDTH signed multiplier and one accumulator compute the Q(WIDTH-QP).QP dot product of two packed LEN-element vectors over LEN clock cycles. It sits beside the spline/FIR datapath wherever a full LEN-multiplier tree is too costly. Its result is bit-identical to the combinational path when saturation is compiled out. A start/busy/done handshake lets the filter control FSM schedule it.

## Interface
- WIDTH, 16, element and result width (signed, two's complement)
- QP, 12, fractional bits; product is rescaled by arithmetic right shift QP
- LEN, 8, vector length (≥2); element i is bits [i*WIDTH +: WIDTH]
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- vec1_packed  input  LEN*WIDTH  operand vector 1, captured on accepted start
- vec2_packed  input  LEN*WIDTH  operand vector 2, captured on accepted start
- busy  output  1  high while in MAC state
- done  output  1  one-cycle pulse when dotp_out is updated
- dotp_out  output  WIDTH  result, held until next completion

## Operation
- States: IDLE, MAC. Reset → IDLE.
- IDLE: start=1 at an edge → latch both vectors into internal registers, idx←0, acc←0, state←MAC. start=0 → remain.
- MAC: each edge adds term(idx) to acc, idx←idx+1. At the edge with idx=LEN-1: dotp_out←final sum, done←1, state←IDLE, idx←0.
- term(i) = low WIDTH bits of ((a_i × b_i) as 2·WIDTH signed) >>> QP (arithmetic, floor toward −∞).
- Accumulation (default): acc is WIDTH bits, wraps mod 2^WIDTH.
- start while busy: ignored, no queuing; input vector changes during MAC have no effect (operands latched).
- done is 0 on every cycle except the one following the final MAC edge.
- rst mid-operation: immediately IDLE, busy=0, done=0, dotp_out=0, acc/idx=0; partial result discarded.

## Timing
- Reset values: busy=0, done=0, dotp_out=0.
- Start accepted at edge E0 → busy=1 after E0; MAC edges E1..E_LEN; done=1 and dotp_out valid after E_LEN; busy=0 in that same cycle.
- Latency start-accept → done = LEN cycles; throughput one result per LEN+1 cycles.
- start=1 in the done cycle is accepted (state is IDLE), giving back-to-back operation with no dead cycle beyond the done cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- DOTP_SEQ_SATURATE_EN defined: acc widened to WIDTH+clog2(LEN) bits (no internal wrap); on completion dotp_out is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Terms themselves are still truncated to WIDTH as above.
- Not defined: WIDTH-bit wrapping accumulator; result bit-exact with the combinational dot product.

## Test plan
- Reset, then all elements 0x0800 (0.5) × 0x0800, start=1 one cycle → busy high 8 cycles, done pulse exactly 8 cycles after accept, dotp_out=0x2000 (2.0).
- vec1 all 0xF800 (−0.5), vec2 all 0x0800 → dotp_out=0xE000 (−2.0); check floor rounding with 0xFFFF×0x0001 term = 0xFFFF (−1 LSB).
- All elements 0x1000 × 0x1000 (sum 8.0) → without macro dotp_out=0x8000; with DOTP_SEQ_SATURATE_EN dotp_out=0x7FFF.
- start pulsed again and vectors changed at cycles 2–5 of MAC → ignored; result equals first vector pair's sum, single done pulse.
- rst asserted mid-MAC (cycle 4), asynchronously between edges → busy/done/dotp_out go 0 immediately; new start after release gives correct full result.
- start held high continuously with fresh vectors each done → consecutive done pulses every 9 cycles, each result matching its captured operands.
